// File: rtl/imem_boot_loader_pkg.sv
// Shared constants, state encoding and helpers
// for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int MAX_WORDS      = 256;
  localparam int CNT_WIDTH      = 9;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_WIDTH     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_RECV  = 3'd1,
    LDR_WRITE = 3'd2,
    LDR_DONE  = 3'd3,
    LDR_ERR   = 3'd4
  } ldr_state_e;

  function automatic logic len_too_big(
    input logic [CNT_WIDTH-1:0] l
  );
    return l > CNT_WIDTH'(MAX_WORDS);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs accepted bytes MSB-first into one word
// and tracks how many bytes of it are in hand.
module imem_boot_loader_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  full
);

  // Only the first three bytes need storage;
  // the fourth is taken straight from byte_in.
  logic [WORD_WIDTH-9:0] word_q, word_d;
  logic [BCNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = {word_q[WORD_WIDTH-17:0], byte_in};
      cnt_d  = cnt_q + BCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word = {word_q, byte_in};
  assign full = (cnt_q == BCNT_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: fills instruction memory from a
// byte stream and holds the CPU until loaded.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  ldr_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic                  we_q, we_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  clr;
  logic                  shift_en;
  logic [WORD_WIDTH-1:0] word;
  logic                  full;

  assign byte_ready = (state_q == LDR_RECV);
  assign shift_en   = byte_ready & byte_valid;

  imem_boot_loader_word_assembler u_asm (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (clr),
    .shift_en (shift_en),
    .byte_in  (byte_in),
    .word     (word),
    .full     (full)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    unique case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (start) begin
          len_d = len;
          idx_d = '0;
          clr   = 1'b1;
          if (len == '0)
            state_d = LDR_DONE;
          else if (len_too_big(len))
            state_d = LDR_ERR;
          else
            state_d = LDR_RECV;
        end
      end
      LDR_RECV: begin
        if (shift_en && full)
          state_d = LDR_WRITE;
      end
      LDR_WRITE: begin
        if (idx_q == len_q - CNT_WIDTH'(1)) begin
          state_d = LDR_DONE;
        end else begin
          idx_d   = idx_q + CNT_WIDTH'(1);
          state_d = LDR_RECV;
        end
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  // Outputs are registered from the next state so
  // they line up with the state they describe.
  always_comb begin
    we_d    = (state_d == LDR_WRITE);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (we_d) begin
      addr_d  = {{(WORD_WIDTH-CNT_WIDTH-2){1'b0}},
                 idx_q, 2'b00};
      wdata_d = word;
    end
    hold_d = (state_d != LDR_DONE);
    done_d = (state_d == LDR_DONE);
    err_d  = (state_d == LDR_ERR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= LDR_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule
